// File: rtl/rr_arbiter_lock.sv
// rr_arbiter_lock: round-robin arbiter with wormhole (packet) locking for one
// router output port. Picks one of NUM_REQ requesters, holds the grant until
// the consumer releases it (or the holder drops its request), then re-arbitrates
// in the same edge so back-to-back packets see no idle bubble.
//
// Optional build macro RR_ARB_TIMEOUT_EN adds a hold counter that forces a
// release after MAX_HOLD cycles and pulses 'timeout'.
//
// The consumer release pulse is carried on port 'release_grant' because
// 'release' is a reserved word in SystemVerilog.

module rr_arbiter_lock #(
   parameter int NUM_REQ  = 5,
   parameter int IDX_W    = 3,
   parameter int MAX_HOLD = 64
) (
   input  logic               clk,
   input  logic               reset,
   input  logic [NUM_REQ-1:0] req,
   input  logic               release_grant,
   output logic               grant_valid,
   output logic [IDX_W-1:0]   grant_idx,
   output logic [NUM_REQ-1:0] grant_oh,
   output logic               timeout
);

   typedef enum logic {
      IDLE,
      HOLD
   } state_t;

   localparam logic [IDX_W-1:0] INVALID = '1;
   localparam logic [IDX_W-1:0] PTR_RST = IDX_W'(NUM_REQ - 1);

   // Refuse to build with a width that would let a real index collide with INVALID.
   if (NUM_REQ < 2 || NUM_REQ > 15 || (1 << IDX_W) <= NUM_REQ || MAX_HOLD < 2) begin : g_bad_cfg
      $error("rr_arbiter_lock: illegal NUM_REQ / IDX_W / MAX_HOLD combination");
   end

   state_t             state, state_nxt;
   logic [IDX_W-1:0]   ptr, ptr_nxt;
   logic               valid_nxt;
   logic [IDX_W-1:0]   idx_nxt;
   logic [NUM_REQ-1:0] oh_nxt;
   logic               timeout_nxt;

   logic               found;
   logic [IDX_W-1:0]   winner;
   logic               held_req;
   logic               force_rel;

`ifdef RR_ARB_TIMEOUT_EN
   localparam int CNT_W = $clog2(MAX_HOLD);
   logic [CNT_W-1:0] hold_cnt, hold_cnt_nxt;

   assign force_rel = (hold_cnt == CNT_W'(MAX_HOLD - 1));
`else
   assign force_rel = 1'b0;
`endif

   // The current holder is still requesting if its one-hot bit meets req.
   assign held_req = |(req & grant_oh);

   // Round-robin search: first requester after ptr, wrapping, so the last winner ranks lowest.
   always_comb begin
      int               cand;
      logic [IDX_W-1:0] cand_idx;
      found    = 1'b0;
      winner   = '0;
      cand     = 0;
      cand_idx = '0;
      for (int k = 1; k <= NUM_REQ; k++) begin
         cand = int'(ptr) + k;
         if (cand >= NUM_REQ) begin
            cand = cand - NUM_REQ;
         end
         cand_idx = IDX_W'(cand);
         if (!found && req[cand_idx]) begin
            found  = 1'b1;
            winner = cand_idx;
         end
      end
   end

   // Next-state and next-output logic: arbitrate from IDLE, or from HOLD on release/abort/timeout.
   always_comb begin
      logic rearb;
      state_nxt   = state;
      ptr_nxt     = ptr;
      valid_nxt   = grant_valid;
      idx_nxt     = grant_idx;
      oh_nxt      = grant_oh;
      timeout_nxt = 1'b0;
      rearb       = 1'b0;
`ifdef RR_ARB_TIMEOUT_EN
      hold_cnt_nxt = hold_cnt;
`endif
      case (state)
         IDLE: begin
            rearb = 1'b1;
         end
         HOLD: begin
            if (release_grant || !held_req || force_rel) begin
               rearb       = 1'b1;
               timeout_nxt = force_rel && !release_grant && held_req;
            end else begin
`ifdef RR_ARB_TIMEOUT_EN
               hold_cnt_nxt = hold_cnt + 1'b1;
`endif
            end
         end
         default: begin
            state_nxt = IDLE;
         end
      endcase

      if (rearb) begin
         if (found) begin
            state_nxt = HOLD;
            ptr_nxt   = winner;
            valid_nxt = 1'b1;
            idx_nxt   = winner;
            oh_nxt    = NUM_REQ'(1) << winner;
`ifdef RR_ARB_TIMEOUT_EN
            hold_cnt_nxt = '0;
`endif
         end else begin
            state_nxt = IDLE;
            valid_nxt = 1'b0;
            idx_nxt   = INVALID;
            oh_nxt    = '0;
         end
      end
   end

   // State, priority pointer and registered grant outputs; reset clears them at once.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state       <= IDLE;
         ptr         <= PTR_RST;
         grant_valid <= 1'b0;
         grant_idx   <= INVALID;
         grant_oh    <= '0;
         timeout     <= 1'b0;
      end else begin
         state       <= state_nxt;
         ptr         <= ptr_nxt;
         grant_valid <= valid_nxt;
         grant_idx   <= idx_nxt;
         grant_oh    <= oh_nxt;
         timeout     <= timeout_nxt;
      end
   end

`ifdef RR_ARB_TIMEOUT_EN
   // Hold-cycle counter: zero on each new grant, counts every cycle the grant is kept.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         hold_cnt <= '0;
      end else begin
         hold_cnt <= hold_cnt_nxt;
      end
   end
`endif

endmodule

// File: doc/rr_arbiter_lock.md
Name: rr_arbiter_lock

Overview:
- Parametrised round-robin arbiter for router output ports. Selects one of NUM_REQ input VCs/ports and holds the grant for a whole packet (wormhole lock) until the consumer signals release.
- Sits between the input VC buffers and the crossbar select of each output port. Generalises the fixed 5-input arbiter with configurable width, packet locking, zero-bubble re-arbitration and an encoded plus one-hot grant.

Parameters:
- NUM_REQ, 5, number of requesters (2..15).
- IDX_W, 3, width of the encoded grant. Must satisfy 2^IDX_W > NUM_REQ so that the all-ones code stays reserved as INVALID.
- MAX_HOLD, 64, hold-cycle limit, used only when RR_ARB_TIMEOUT_EN is defined.

Ports:
- clk  in  1  clock, rising edge.
- reset  in  1  reset, asynchronous, active-high.
- req  in  NUM_REQ  request vector. Bit i high means requester i has a flit ready (buffer not empty).
- release  in  1  consumer pulse: tail flit of the current packet transferred, so free the grant.
- grant_valid  out  1  a grant is currently held.
- grant_idx  out  IDX_W  encoded granted requester; all-ones (INVALID) when grant_valid=0.
- grant_oh  out  NUM_REQ  one-hot grant; zero when grant_valid=0.
- timeout  out  1  one-cycle pulse on forced release (always 0 without the macro).

Behaviour:
- All outputs are registered. On reset: grant_valid=0, grant_idx=all-ones, grant_oh=0, timeout=0, priority pointer ptr=NUM_REQ-1, so requester 0 has first priority.
- Two states: IDLE and HOLD.
- Round-robin search: scan requesters ptr+1, ptr+2, … modulo NUM_REQ, wrapping from NUM_REQ-1 to 0. Pick the first requester with req set. This means the last-granted requester has the lowest priority.
- IDLE:
  - If any req bit is set at a rising edge, the winner is registered. Next cycle: grant_valid=1, the grant outputs show the winner, ptr=winner, state=HOLD. Latency is one cycle from req to grant.
  - If no req bit is set, stay in IDLE with outputs in their reset values.
- HOLD:
  - Grant is frozen regardless of other req changes.
  - release=1: re-arbitrate in the same edge, excluding nothing. The rotated pointer gives others priority. If any req is set, the new grant appears next cycle with no idle bubble. Otherwise go to IDLE.
  - req[grant] drops while release=0: treat as abort and apply the same re-arbitration as release.
- release while in IDLE is ignored.
- Single requester: it can be re-granted back-to-back after each release.
- All NUM_REQ requesting continuously with a release every cycle: grants rotate 0,1,…,NUM_REQ-1,0 in order.
- Next-state logic is fully combinational over state, ptr, req and release, with no incomplete sensitivity. req may change on any edge; it is sampled only at rising clk.
- Reset asserted mid-packet: outputs clear immediately (asynchronously), and the pointer returns to NUM_REQ-1.

Optional Feature:
- Macro: RR_ARB_TIMEOUT_EN.
- Defined: a hold counter clears on each new grant and increments each cycle in HOLD.
  - When the count reaches MAX_HOLD-1 without release, force a release.
  - Re-arbitrate exactly as for release, and pulse timeout=1 for one cycle, aligned with the new grant outputs.
  - Counter width is clog2(MAX_HOLD).
- Not defined: no counter; timeout is tied to 0; the grant is held indefinitely until release or abort.

Test Plan:
- Reset, then req=5'b00000 for 5 cycles -> grant_valid=0, grant_idx=3'b111, grant_oh=0 throughout.
- req=5'b10101 held, release pulsed every cycle -> grant_idx sequence 0,2,4,0,2; no gap cycles with grant_valid=0.
- req=5'b00110, no release for 10 cycles -> grant_idx=1 held for all 10 cycles. Then release -> grant_idx=2 next cycle.
- Grant held on index 3, req[3] drops with release=0 and req=5'b00001 -> next cycle grant_idx=0, grant_oh=5'b00001.
- Reset asserted mid-HOLD on index 2 -> outputs clear immediately. After reset deasserts with req=5'b11111 -> first grant_idx=0.
- With RR_ARB_TIMEOUT_EN and MAX_HOLD=4, req=5'b00011 and no release -> grant 0 for 4 cycles, then grant_idx=1 with timeout=1 for one cycle.
